event_playback_gen: RTL and testbench

Synthesizable, parametrised event playback generator that drives L1A, ALCT/TMB data-valid and per-CFEB LCT strobes from a loadable timestamped event table. It replaces file-driven bench stimulus with an on-chip source for board self-test and lab bring-up. It sits upstream of the trigger/DAQ control path.
- Generalisations: CFEB count and table depth are parametrised.
- Added behaviour: start/stop/pause control, loop mode, sequence-error and overflow detection.

---
 rtl/event_playback_pkg.sv | 31 +++
 rtl/event_table.sv | 58 +++++
 rtl/event_playback_gen.sv | 209 ++++++++++++++++++++
 tb/tb_event_playback_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_playback_pkg.sv
// Shared types and entry layout for the event playback generator.
// Entry layout (LSB first): lct, tmb_dav, alct_dav, l1a, ts.
package event_playback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ent_w(input int ncfeb, input int ts_w);
        return ts_w + ncfeb + 3;
    endfunction

    function automatic int off_tmb(input int ncfeb);
        return ncfeb;
    endfunction

    function automatic int off_alct(input int ncfeb);
        return ncfeb + 1;
    endfunction

    function automatic int off_l1a(input int ncfeb);
        return ncfeb + 2;
    endfunction

    function automatic int off_ts(input int ncfeb);
        return ncfeb + 3;
    endfunction

endpackage

// File: rtl/event_table.sv
// Append-only event table with asynchronous read and entry counter.
// Writes and clears are honoured only in IDLE; misuse sets a sticky flag.
module event_table #(
    parameter int DEPTH = 16,
    parameter int EW    = 26,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_idle,
    input  logic          i_clr,
    input  logic          i_wr,
    input  logic [EW-1:0] i_wdata,
    input  logic [AW-1:0] i_rd_ptr,
    output logic [EW-1:0] o_rdata,
    output logic [AW:0]   o_n_events,
    output logic          o_load_ovf
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_n;
    logic          r_ovf;
    logic          w_full;
    logic          w_push;
    logic          w_bad;

    assign w_full = (r_n == FULL);
    assign w_push = i_idle && !i_clr && i_wr && !w_full;
    // tbl_clr wins over a same-cycle write, so that write is not an error
    assign w_bad  = i_idle ? (i_wr && !i_clr && w_full)
                           : (i_wr || i_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n   <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_idle && i_clr)
                r_n <= '0;
            else if (w_push)
                r_n <= r_n + (AW+1)'(1);
            if (w_bad)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_n[AW-1:0]] <= i_wdata;
    end

    assign o_rdata    = r_mem[i_rd_ptr];
    assign o_n_events = r_n;
    assign o_load_ovf = r_ovf;

endmodule

// File: rtl/event_playback_gen.sv
// Timestamped event playback: FSM, time base and registered strobes.
// Define PLAYBACK_CNT_EN to add the l1a_cnt / lct_evt_cnt counters.
module event_playback_gen
    import event_playback_pkg::*;
#(
    parameter int NCFEB  = 7,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int LOOP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_mode,
    input  logic                     tbl_clr,
    input  logic                     wr_en,
    input  logic [TS_W-1:0]          wr_ts,
    input  logic                     wr_l1a,
    input  logic                     wr_alct_dav,
    input  logic                     wr_tmb_dav,
    input  logic [NCFEB-1:0]         wr_lct,
    output logic                     l1a,
    output logic                     alct_dav,
    output logic                     tmb_dav,
    output logic [NCFEB-1:0]         lct,
    output logic                     busy,
    output logic                     done,
    output logic                     seq_err,
    output logic                     load_ovf,
    output logic [$clog2(DEPTH):0]   n_events,
    output logic [LOOP_W-1:0]        loop_cnt
`ifdef PLAYBACK_CNT_EN
    ,
    output logic [31:0]              l1a_cnt,
    output logic [31:0]              lct_evt_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = ent_w(NCFEB, TS_W);
    localparam int OT = off_ts(NCFEB);

    state_t            r_state;
    state_t            w_next;
    logic [TS_W-1:0]   r_ts_cnt;
    logic [TS_W-1:0]   r_prev_ts;
    logic              r_prev_emit;
    logic [AW-1:0]     r_rd_ptr;
    logic [LOOP_W-1:0] r_loop_cnt;
    logic              r_seq_err;
    logic              r_l1a;
    logic              r_alct;
    logic              r_tmb;
    logic [NCFEB-1:0]  r_lct;

    logic [EW-1:0]     w_entry;
    logic [EW-1:0]     w_wdata;
    logic [TS_W-1:0]   w_ts;
    logic              w_run;
    logic              w_start_ok;
    logic              w_act;
    logic              w_match;
    logic              w_skip;
    logic              w_consume;
    logic              w_last;

    assign w_wdata = {wr_ts, wr_l1a, wr_alct_dav,
                      wr_tmb_dav, wr_lct};

    event_table #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (AW)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_idle     (r_state == ST_IDLE),
        .i_clr      (tbl_clr),
        .i_wr       (wr_en),
        .i_wdata    (w_wdata),
        .i_rd_ptr   (r_rd_ptr),
        .o_rdata    (w_entry),
        .o_n_events (n_events),
        .o_load_ovf (load_ovf)
    );

    assign w_ts       = w_entry[OT +: TS_W];
    assign w_run      = (r_state == ST_RUN);
    assign w_start_ok = start && !stop && (n_events != '0);
    assign w_act      = w_run && en && !stop && !w_start_ok;
    // an entry sharing the timestamp of the one just emitted follows it
    assign w_match    = (w_ts == r_ts_cnt) ||
                        (r_prev_emit && (w_ts == r_prev_ts));
    assign w_skip     = !w_match && (w_ts < r_ts_cnt);
    assign w_consume  = w_act && (w_match || w_skip);
    assign w_last     = ({1'b0, r_rd_ptr} ==
                         (n_events - (AW+1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (stop)
            w_next = ST_IDLE;
        else if (w_start_ok)
            w_next = ST_RUN;
        else if (w_consume && w_last && !loop_mode)
            w_next = ST_DONE;
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt    <= '0;
            r_prev_ts   <= '0;
            r_prev_emit <= 1'b0;
            r_rd_ptr    <= '0;
            r_loop_cnt  <= '0;
            r_seq_err   <= 1'b0;
            r_l1a       <= 1'b0;
            r_alct      <= 1'b0;
            r_tmb       <= 1'b0;
            r_lct       <= '0;
        end else begin
            r_l1a  <= 1'b0;
            r_alct <= 1'b0;
            r_tmb  <= 1'b0;
            r_lct  <= '0;
            if (stop) begin
                r_ts_cnt    <= '0;
                r_rd_ptr    <= '0;
                r_prev_emit <= 1'b0;
            end else if (w_start_ok) begin
                r_ts_cnt    <= '0;
                r_rd_ptr    <= '0;
                r_prev_emit <= 1'b0;
                r_loop_cnt  <= '0;
                r_seq_err   <= 1'b0;
            end else if (w_act) begin
                if (w_match) begin
                    r_l1a  <= w_entry[off_l1a(NCFEB)];
                    r_alct <= w_entry[off_alct(NCFEB)];
                    r_tmb  <= w_entry[off_tmb(NCFEB)];
                    r_lct  <= w_entry[NCFEB-1:0];
                end
                r_prev_emit <= w_match;
                r_prev_ts   <= w_ts;
                if (w_skip)
                    r_seq_err <= 1'b1;
                if (w_consume && w_last && loop_mode) begin
                    r_ts_cnt    <= '0;
                    r_rd_ptr    <= '0;
                    r_prev_emit <= 1'b0;
                    if (r_loop_cnt != '1)
                        r_loop_cnt <= r_loop_cnt + 1'b1;
                end else begin
                    r_ts_cnt <= r_ts_cnt + 1'b1;
                    if (w_consume)
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    assign l1a      = r_l1a;
    assign alct_dav = r_alct;
    assign tmb_dav  = r_tmb;
    assign lct      = r_lct;
    assign seq_err  = r_seq_err;
    assign loop_cnt = r_loop_cnt;

`ifdef PLAYBACK_CNT_EN
    logic [31:0] r_l1a_cnt;
    logic [31:0] r_lct_cnt;
    logic        w_emit;

    assign w_emit = w_act && w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l1a_cnt <= '0;
            r_lct_cnt <= '0;
        end else if (w_start_ok) begin
            r_l1a_cnt <= '0;
            r_lct_cnt <= '0;
        end else if (w_emit) begin
            if (w_entry[off_l1a(NCFEB)] && (r_l1a_cnt != '1))
                r_l1a_cnt <= r_l1a_cnt + 1'b1;
            if ((|w_entry[NCFEB-1:0]) && (r_lct_cnt != '1))
                r_lct_cnt <= r_lct_cnt + 1'b1;
        end
    end

    assign l1a_cnt     = r_l1a_cnt;
    assign lct_evt_cnt = r_lct_cnt;
`endif

endmodule

// File: tb/tb_event_playback_gen.sv
// Scoreboard bench for event_playback_gen: expected strobes queued at
// start, popped and compared whenever the DUT emits.
module tb_event_playback_gen;

    localparam int NCFEB  = 7;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int LOOP_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop_mode = 1'b0;
    logic tbl_clr = 1'b0;
    logic wr_en = 1'b0;
    logic [TS_W-1:0] wr_ts = '0;
    logic wr_l1a = 1'b0;
    logic wr_alct_dav = 1'b0;
    logic wr_tmb_dav = 1'b0;
    logic [NCFEB-1:0] wr_lct = '0;

    logic l1a, alct_dav, tmb_dav;
    logic [NCFEB-1:0] lct;
    logic busy, done, seq_err, load_ovf;
    logic [$clog2(DEPTH):0] n_events;
    logic [LOOP_W-1:0] loop_cnt;
`ifdef PLAYBACK_CNT_EN
    logic [31:0] l1a_cnt, lct_evt_cnt;
`endif

    event_playback_gen #(
        .NCFEB (NCFEB), .DEPTH (DEPTH),
        .TS_W (TS_W), .LOOP_W (LOOP_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .en (en),
        .start (start), .stop (stop),
        .loop_mode (loop_mode), .tbl_clr (tbl_clr),
        .wr_en (wr_en), .wr_ts (wr_ts),
        .wr_l1a (wr_l1a), .wr_alct_dav (wr_alct_dav),
        .wr_tmb_dav (wr_tmb_dav), .wr_lct (wr_lct),
        .l1a (l1a), .alct_dav (alct_dav),
        .tmb_dav (tmb_dav), .lct (lct),
        .busy (busy), .done (done),
        .seq_err (seq_err), .load_ovf (load_ovf),
        .n_events (n_events), .loop_cnt (loop_cnt)
`ifdef PLAYBACK_CNT_EN
        ,
        .l1a_cnt (l1a_cnt), .lct_evt_cnt (lct_evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int t0 = 0;

    typedef struct {
        int         c;
        logic [9:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h @cyc %0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [9:0] b);
        exp_t e;
        e.c = c;
        e.b = b;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (l1a || alct_dav || tmb_dav || (|lct))) begin
            if (sb.size() == 0) begin
                chk("spurious", {l1a, alct_dav, tmb_dav, lct}, 0);
            end else begin
                m_e = sb.pop_front();
                chk("evt_cyc", cyc, m_e.c);
                chk("evt_bits", {l1a, alct_dav, tmb_dav, lct}, m_e.b);
            end
        end
    end

    task automatic wait_to(input int tgt);
        int g = 0;
        while (cyc < tgt && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < tgt) chk("wait_timeout", cyc, tgt);
    endtask

    task automatic wr(input int ts, input logic a, input logic b,
                      input logic c, input logic [6:0] l);
        wr_en = 1'b1;
        wr_ts = TS_W'(ts);
        wr_l1a = a;
        wr_alct_dav = b;
        wr_tmb_dav = c;
        wr_lct = l;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clr_tbl();
        tbl_clr = 1'b1;
        @(negedge clk);
        tbl_clr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic load_a();
        clr_tbl();
        wr(3, 1, 0, 0, 7'h00);
        wr(5, 0, 1, 0, 7'h00);
        wr(5, 0, 0, 1, 7'h00);
        wr(9, 0, 0, 0, 7'h41);
    endtask

    task automatic push_a(input int b, input int d);
        push(b + 4, 10'h200);
        push(b + 6 + d, 10'h100);
        push(b + 7 + d, 10'h080);
        push(b + 10 + d, 10'h041);
    endtask

    task automatic check_reset();
        chk("rst_strb", {l1a, alct_dav, tmb_dav, lct}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_flags", {seq_err, load_ovf}, 0);
        chk("rst_nev", n_events, 0);
        chk("rst_loop", loop_cnt, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);

        // single pass with equal back-to-back timestamps
        load_a();
        chk("nev_a", n_events, 4);
        do_start();
        chk("busy_run", busy, 1);
        push_a(t0, 0);
        wait_to(t0 + 14);
        chk("t1_done", {busy, done}, 2'b01);
        chk("t1_seq", seq_err, 0);
        chk("t1_sb", sb.size(), 0);
`ifdef PLAYBACK_CNT_EN
        chk("l1a_cnt", l1a_cnt, 1);
        chk("lct_cnt", lct_evt_cnt, 1);
`endif
        do_stop();
        chk("stop_done", done, 0);

        // loop mode, three passes of period 10
        loop_mode = 1'b1;
        do_start();
        for (int p = 0; p < 3; p++) push_a(t0 + 10 * p, 0);
        wait_to(t0 + 31);
        chk("loop_cnt", loop_cnt, 3);
        chk("loop_done", done, 0);
        do_stop();
        loop_mode = 1'b0;
        chk("loop_busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("t2_sb", sb.size(), 0);

        // late entry skipped
        clr_tbl();
        wr(4, 1, 0, 0, 7'h00);
        wr(2, 0, 1, 0, 7'h00);
        wr(8, 0, 0, 1, 7'h00);
        do_start();
        push(t0 + 5, 10'h200);
        push(t0 + 9, 10'h080);
        wait_to(t0 + 12);
        chk("skip_seq", seq_err, 1);
        chk("skip_done", done, 1);
        chk("t3_sb", sb.size(), 0);
        do_stop();
        chk("seq_sticky", seq_err, 1);

        // en held low for 6 cycles before ts=5
        load_a();
        do_start();
        chk("seq_clr", seq_err, 0);
        push_a(t0, 6);
        wait_to(t0 + 4);
        en = 1'b0;
        wait_to(t0 + 10);
        en = 1'b1;
        wait_to(t0 + 20);
        chk("pause_done", done, 1);
        chk("t4_sb", sb.size(), 0);
        do_stop();

        // overflow by DEPTH+1 writes
        clr_tbl();
        chk("ovf_pre", load_ovf, 0);
        for (int i = 0; i <= DEPTH; i++) wr(i, 0, 0, 0, 7'h00);
        chk("ovf_nev", n_events, DEPTH);
        chk("ovf_flag", load_ovf, 1);

        // async reset from IDLE, then write during RUN and early stop
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        load_a();
        do_start();
        wr(1, 1, 1, 1, 7'h7f);
        chk("run_wr_ovf", load_ovf, 1);
        chk("run_wr_nev", n_events, 4);
        push(t0 + 4, 10'h200);
        wait_to(t0 + 5);
        do_stop();
        chk("stop_busy", busy, 0);
        repeat (8) @(negedge clk);
        chk("t6_sb", sb.size(), 0);
        chk("stop_nev", n_events, 4);

        // async reset mid-run while a strobe is high
        do_start();
        wait_to(t0 + 3);
        @(posedge clk);
        #1;
        chk("pre_rst_l1a", l1a, 1);
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("sb_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
